// File: rtl/tppe_psum_if.sv
// Handshake bundle between the spike/weight feeder, the partial-sum
// accumulator and the downstream LIF stage.
interface tppe_psum_if #(
  parameter int T  = 16,
  parameter int Q  = 10,
  parameter int W  = 8,
  parameter int CW = 8
) ();

  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [T-1:0]     in_spikes;
  logic [W-1:0]     in_weight;
  logic             in_last;
  logic [T*Q-1:0]   result_data;
  logic             result_val;
  logic             result_ready;
  logic [CW-1:0]    beat_count;
  logic             sat_flag;

  // Feeder / consumer side: drives beats and the release, observes results.
  modport master (
    output clear, in_valid, in_spikes, in_weight, in_last, result_ready,
    input  in_ready, result_data, result_val, beat_count, sat_flag
  );

  // Accumulator side.
  modport slave (
    input  clear, in_valid, in_spikes, in_weight, in_last, result_ready,
    output in_ready, result_data, result_val, beat_count, sat_flag
  );

endinterface

// File: rtl/tppe_psum_accumulator.sv
// Accumulates spike-gated weights into T saturating per-timestep partial
// sums for one neuron, then holds the packed result until the LIF stage
// takes it.
module tppe_psum_accumulator #(
  parameter int T  = 16,
  parameter int Q  = 10,
  parameter int W  = 8,
  parameter int CW = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  tppe_psum_if.slave   bus
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t          state_q;
  logic [Q-1:0]    acc_q    [T];
  logic [Q-1:0]    acc_next [T];
  logic [CW-1:0]   beat_q;
  logic [CW-1:0]   beat_next;
  logic            sat_q;
  logic            any_sat;
  logic            ready_q;
  logic            val_q;
  logic [Q:0]      w_ext;
  logic [Q:0]      sum;

  // One extra bit of headroom so the carry out signals saturation.
  assign w_ext = (Q+1)'(bus.in_weight);

  // Candidate sums for an accepted beat, clamped to the Q-bit maximum.
  always_comb begin
    // NOTE: combinational logic uses blocking '=' and assigns every output a
    // default first, so no path leaves a value held (which would infer a latch).
    any_sat = 1'b0;
    sum     = '0;
    for (int t = 0; t < T; t++) begin
      sum = {1'b0, acc_q[t]} + (bus.in_spikes[t] ? w_ext : '0);
      if (sum[Q]) begin
        acc_next[t] = '1;
        any_sat     = 1'b1;
      end else begin
        acc_next[t] = sum[Q-1:0];
      end
    end
  end

  // Beat counter sticks at its maximum instead of wrapping.
  assign beat_next = (beat_q == {CW{1'b1}}) ? beat_q : beat_q + CW'(1);

  // State, accumulators and handshake outputs; clear overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values. The accumulator array is reset too: result_data must
    // read zero straight out of reset.
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '{default: '0};
      beat_q  <= '0;
      sat_q   <= 1'b0;
      ready_q <= 1'b1;
      val_q   <= 1'b0;
    end else if (bus.clear) begin
      state_q <= ACCUM;
      acc_q   <= '{default: '0};
      beat_q  <= '0;
      sat_q   <= 1'b0;
      ready_q <= 1'b1;
      val_q   <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (bus.in_valid && ready_q) begin
            acc_q  <= acc_next;
            beat_q <= beat_next;
            sat_q  <= sat_q | any_sat;
            if (bus.in_last) begin
              state_q <= HOLD;
              ready_q <= 1'b0;
              val_q   <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.result_ready) begin
            state_q <= ACCUM;
            acc_q   <= '{default: '0};
            beat_q  <= '0;
            sat_q   <= 1'b0;
            ready_q <= 1'b1;
            val_q   <= 1'b0;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  // Pack the per-timestep sums, timestep t in slice [(t+1)*Q-1 -: Q].
  always_comb begin
    bus.result_data = '0;
    for (int t = 0; t < T; t++) begin
      bus.result_data[t*Q +: Q] = acc_q[t];
    end
  end

  assign bus.in_ready   = ready_q;
  assign bus.result_val = val_q;
  assign bus.beat_count = beat_q;
  assign bus.sat_flag   = sat_q;

endmodule

// File: tb/tb_tppe_psum_accumulator.sv
// Directed bench for tppe_psum_accumulator: the stimulus process pushes the
// hand-computed result of each neuron into a queue, and a monitor pops and
// compares whenever result_val rises.
module tb_tppe_psum_accumulator;

  localparam int T  = 16;
  localparam int Q  = 10;
  localparam int W  = 8;
  localparam int CW = 8;
  localparam int DW = T * Q;

  typedef struct {
    logic [DW-1:0] data;
    logic [CW-1:0] beats;
    logic          sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  logic prev_val = 1'b0;

  tppe_psum_if #(.T(T), .Q(Q), .W(W), .CW(CW)) bus ();

  tppe_psum_accumulator #(.T(T), .Q(Q), .W(W), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-timestep expectation: v1 where m1 is set plus v2 where m2 is set.
  function automatic logic [DW-1:0] exp_data(input logic [T-1:0] m1, input int v1,
                                             input logic [T-1:0] m2, input int v2);
    logic [DW-1:0] d;
    d = '0;
    for (int t = 0; t < T; t++) begin
      d[t*Q +: Q] = Q'((m1[t] ? v1 : 0) + (m2[t] ? v2 : 0));
    end
    return d;
  endfunction

  function automatic exp_t mk_exp(input logic [DW-1:0] d, input int beats, input logic sat);
    exp_t e;
    e.data  = d;
    e.beats = CW'(beats);
    e.sat   = sat;
    return e;
  endfunction

  // Monitor: compare each newly presented result against the queue head.
  always @(negedge clk) begin
    if (rst_n && bus.result_val && !prev_val) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("mon_result_data", bus.result_data, e.data);
        check("mon_beat_count", DW'(bus.beat_count), DW'(e.beats));
        check("mon_sat_flag", DW'(bus.sat_flag), DW'(e.sat));
      end
    end
    prev_val = bus.result_val;
  end

  // Called at posedge+1; presents one beat and returns at posedge+1 after acceptance.
  task automatic send_beat(input logic [T-1:0] spikes, input logic [W-1:0] w, input logic last);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 50) check("in_ready_timeout", 0, 1);
    bus.in_valid  = 1'b1;
    bus.in_spikes = spikes;
    bus.in_weight = w;
    bus.in_last   = last;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_spikes = '0;
    bus.in_weight = '0;
  endtask

  task automatic release_result();
    bus.result_ready = 1'b1;
    @(posedge clk); #1;
    bus.result_ready = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_result_val"}, DW'(bus.result_val), 0);
    check({tag, "_in_ready"}, DW'(bus.in_ready), 1);
    check({tag, "_result_data"}, bus.result_data, 0);
    check({tag, "_beat_count"}, DW'(bus.beat_count), 0);
    check({tag, "_sat_flag"}, DW'(bus.sat_flag), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.clear        = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_spikes    = '0;
    bus.in_weight    = '0;
    bus.in_last      = 1'b0;
    bus.result_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: reset values
    check_idle("reset");

    // 2: one-beat neuron, result visible one cycle after acceptance
    exp_q.push_back(mk_exp(exp_data(16'h0005, 7, 16'h0000, 0), 1, 1'b0));
    send_beat(16'h0005, 8'd7, 1'b1);
    check("t2_result_val", DW'(bus.result_val), 1);
    check("t2_in_ready", DW'(bus.in_ready), 0);
    @(posedge clk); #1;
    release_result();

    // 3: three beats 3/5/2 on all timesteps; result_ready in ACCUM ignored
    exp_q.push_back(mk_exp(exp_data(16'hFFFF, 10, 16'h0000, 0), 3, 1'b0));
    bus.result_ready = 1'b1;
    send_beat(16'hFFFF, 8'd3, 1'b0);
    bus.result_ready = 1'b0;
    check("t3_rr_in_accum_beats", DW'(bus.beat_count), 1);
    send_beat(16'hFFFF, 8'd5, 1'b0);
    send_beat(16'hFFFF, 8'd2, 1'b1);
    // Hold for 5 cycles while a beat is offered; it must be ignored.
    bus.in_valid  = 1'b1;
    bus.in_spikes = 16'hFFFF;
    bus.in_weight = 8'd50;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("t3_hold_val", DW'(bus.result_val), 1);
      check("t3_hold_data", bus.result_data, exp_data(16'hFFFF, 10, 16'h0000, 0));
      check("t3_hold_beats", DW'(bus.beat_count), 3);
    end
    bus.in_valid  = 1'b0;
    bus.in_spikes = '0;
    bus.in_weight = '0;
    release_result();

    // 4: saturation at 1023 on timestep 15, then an empty-spike last beat
    exp_q.push_back(mk_exp(exp_data(16'h8000, 1023, 16'h0000, 0), 6, 1'b1));
    for (int i = 0; i < 4; i++) send_beat(16'h8000, 8'd255, 1'b0);
    check("t4_no_sat_yet", DW'(bus.sat_flag), 0);
    check("t4_acc_1020", bus.result_data, exp_data(16'h8000, 1020, 16'h0000, 0));
    send_beat(16'h8000, 8'd255, 1'b0);
    check("t4_sat_set", DW'(bus.sat_flag), 1);
    send_beat(16'h0000, 8'd99, 1'b1);
    @(posedge clk); #1;

    // 5: release, then a new neuron without residue
    release_result();
    check_idle("t5_release");
    exp_q.push_back(mk_exp(exp_data(16'h0001, 4, 16'h0002, 10), 2, 1'b0));
    send_beat(16'h0003, 8'd4, 1'b0);
    send_beat(16'h0002, 8'd6, 1'b1);
    @(posedge clk); #1;
    release_result();

    // 6a: clear with a valid beat mid-accumulation drops the beat
    send_beat(16'hFFFF, 8'd9, 1'b0);
    bus.clear     = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_spikes = 16'hFFFF;
    bus.in_weight = 8'd20;
    bus.in_last   = 1'b1;
    @(posedge clk); #1;
    bus.clear     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    check_idle("t6_clear");
    exp_q.push_back(mk_exp(exp_data(16'h0100, 1, 16'h0000, 0), 1, 1'b0));
    send_beat(16'h0100, 8'd1, 1'b1);

    // 6b: asynchronous reset while holding
    @(negedge clk); #2;
    check("t6_in_hold", DW'(bus.result_val), 1);
    rst_n = 1'b0;
    #1;
    check_idle("t6_async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle("t6_after_rst");

    check("scoreboard_empty", DW'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
